// File: rtl/pkt_fifo_arb_pkg.sv
// pkt_fifo_arb_pkg: state encoding, byte width and index-width helper shared by the arbiter files
package pkt_fifo_arb_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pkt_fifo_arb_if.sv
// pkt_fifo_arb_if: requester byte streams, FIFO write port and arbiter status
interface pkt_fifo_arb_if #(parameter int NREQ = 4);
    import pkt_fifo_arb_pkg::*;
    logic [BYTE_W*NREQ-1:0] in_data;
    logic [NREQ-1:0]        in_last;
    logic [NREQ-1:0]        in_valid;
    logic [NREQ-1:0]        in_ready;
    logic [BYTE_W-1:0]      wr_data;
    logic                   wr_last;
    logic                   wr_ena;
    logic                   full;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    modport master (
        input  in_data, in_last, in_valid, full,
        output in_ready, wr_data, wr_last, wr_ena, grant, busy
    );
    modport slave (
        output in_data, in_last, in_valid, full,
        input  in_ready, wr_data, wr_last, wr_ena, grant, busy
    );
endinterface

// File: rtl/pkt_fifo_arb_rr_pick.sv
// pkt_fifo_arb_rr_pick: picks the first set request bit at or after ptr, wrapping modulo N
module pkt_fifo_arb_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic [PW-1:0] o_idx
);
    logic [PW-1:0] w_j;
    // scan from the farthest slot back to ptr so the nearest requester overwrites the others
    always_comb begin
        o_pick = '0;
        o_idx = '0;
        w_j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = PW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_pick = N'(1) << w_j;
                o_idx = w_j;
            end
        end
    end
endmodule

// File: rtl/pkt_fifo_arb.sv
// pkt_fifo_arb: packet-granular round-robin arbiter feeding one pkt_fifo write port
// PKT_ARB_PRIO0_EN: when defined, requester 0 wins every arbitration it takes part in and ptr is kept
module pkt_fifo_arb import pkt_fifo_arb_pkg::*; #(
    parameter int NREQ = 4
) (
    input logic           clk,
    input logic           rst,
    pkt_fifo_arb_if.master bus
);
    localparam int PW = idx_w(NREQ);
    state_t          r_state, w_state;
    logic [NREQ-1:0] r_grant, w_grant, w_pick;
    logic [PW-1:0]   r_own, w_own, r_ptr, w_ptr, w_idx;
    logic            w_busy, w_beat_last, w_prio;
    pkt_fifo_arb_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .i_req  (bus.in_valid),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_idx)
    );
    // route the owner's lane to the FIFO; everything is quiet outside a packet
    always_comb begin
        w_busy = r_state == BUSY;
        bus.busy = w_busy;
        bus.grant = r_grant;
        bus.in_ready = (w_busy && !bus.full) ? r_grant : '0;
        bus.wr_data = w_busy ? bus.in_data[BYTE_W*r_own +: BYTE_W] : '0;
        bus.wr_last = w_busy && bus.in_last[r_own];
        bus.wr_ena = w_busy && bus.in_valid[r_own] && !bus.full;
        w_beat_last = bus.wr_ena && bus.wr_last;
    end
    // arbitrate in IDLE; hold the grant until the last byte of the packet is written
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_own = r_own;
        w_ptr = r_ptr;
`ifdef PKT_ARB_PRIO0_EN
        w_prio = bus.in_valid[0];
`else
        w_prio = 1'b0;
`endif
        if (r_state == IDLE) begin
            if (|bus.in_valid) begin
                w_state = BUSY;
                w_grant = w_prio ? NREQ'(1) : w_pick;
                w_own = w_prio ? '0 : w_idx;
                w_ptr = w_prio ? r_ptr : (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end else if (w_beat_last) begin
            w_state = IDLE;
            w_grant = '0;
        end
    end
    // state, owner and pointer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_own <= '0;
            r_ptr <= '0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_own <= w_own;
            r_ptr <= w_ptr;
        end
    end
endmodule

// File: doc/pkt_fifo_arb.md
# pkt_fifo_arb

Packet-granular round-robin arbiter that shares one `pkt_fifo` write port between NREQ byte-stream packet sources. A requester holds the grant from its first accepted byte until its `last` byte is written, so packets never interleave inside the FIFO. It sits directly in front of `pkt_fifo` and drives its `wr_data` / `wr_last` / `wr_ena` inputs, observing `full`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset; 0 = reset.
- `in_data` in 8*NREQ: requester i byte on bits [8i+7:8i].
- `in_last` in NREQ: bit i marks the final byte of requester i's packet.
- `in_valid` in NREQ: requester i presents a byte.
- `in_ready` out NREQ: requester i byte is consumed this cycle when `in_valid[i] & in_ready[i]`.
- `wr_data` out 8: to `pkt_fifo` `wr_data`.
- `wr_last` out 1: to `pkt_fifo` `wr_last`.
- `wr_ena` out 1: to `pkt_fifo` `wr_ena`.
- `full` in 1: from `pkt_fifo` `full`.
- `grant` out NREQ: one-hot owner, 0 when idle.
- `busy` out 1: a packet is in progress.

## Operation
- States: IDLE, BUSY. Reset → IDLE, `grant`=0, round-robin pointer `ptr`=0.
- IDLE: if any `in_valid` is set, select the first requester at or after `ptr` (mod NREQ) with `in_valid` set. Register it as `grant`, set `ptr` = selected+1 mod NREQ, and go to BUSY. No bytes are accepted in IDLE: `in_ready`=0, `wr_ena`=0.
- BUSY, owner g:
  - `in_ready[g]` = ~`full`; all other `in_ready` bits = 0.
  - `wr_data` = `in_data[g]`, `wr_last` = `in_last[g]`, `wr_ena` = `in_valid[g]` & ~`full`. These are combinational from the registered grant.
- A beat where `wr_ena` and `wr_last` are both 1 → IDLE next cycle with `grant` cleared.
- `in_valid[g]` low mid-packet: hold the grant indefinitely and insert no bytes. No timeout.
- `full` high: no beat. The grant is held and `in_ready[g]`=0.
- Outputs when not BUSY: `wr_data`=0, `wr_last`=0.
- Reset asserted mid-packet: next cycle IDLE, `grant`=0, `ptr`=0. The partial packet is not terminated; FIFO reset is the system's responsibility.
- `busy` = (state==BUSY).

## Timing
- Request to grant: 1 cycle. IDLE with valid at edge n gives `grant` registered at edge n+1, and the first byte can be written in cycle n+1.
- Throughput: 1 byte/cycle within a packet. There is exactly one idle cycle between consecutive packets, which is the IDLE arbitration cycle.
- Single-byte packet (`in_last` on first byte) occupies 2 cycles total.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0.

## Configuration
- `PKT_ARB_PRIO0_EN` defined: requester 0 has strict priority in IDLE. If `in_valid[0]` is set it wins regardless of `ptr`, and `ptr` is left unchanged. Other requesters arbitrate round-robin as above when `in_valid[0]`=0. An in-progress packet is never preempted.
- `PKT_ARB_PRIO0_EN` undefined: pure round-robin over all requesters.

## Structure
- The shared package holds the state encoding (IDLE=0, BUSY=1) and the byte width constant (8).
- One sub-module, `rr_pick`: combinational first-set-bit-at-or-after-`ptr` selector. Inputs: request vector and `ptr`. Outputs: one-hot pick and its index. The state register, grant, `ptr` and muxing stay in `pkt_fifo_arb`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all `in_valid`=1 → `grant`=0, `wr_ena`=0, `in_ready`=0, `busy`=0 throughout.
- Single source: requester 2 sends 8 bytes 0x10..0x17 with `last` on 0x17, NREQ=4 →
  - `grant`=4'b0100 one cycle after valid;
  - 8 consecutive `wr_ena` beats carrying 0x10..0x17;
  - `wr_last` only on 0x17;
  - IDLE the following cycle.
- Round-robin: all 4 requesters send 3-byte packets continuously →
  - grant order 0,1,2,3,0;
  - each packet is contiguous in `wr_data`;
  - one idle cycle between packets.
- Backpressure: `full`=1 for cycles 2–5 of a 6-byte packet → `wr_ena`=0 and `in_ready[g]`=0 while `full`=1; no byte lost or duplicated; the grant does not change.
- Source stall plus reset: owner drops `in_valid` for 10 cycles mid-packet while others request → no grant change and no writes. Then `rst`=0 for 1 cycle → IDLE, and `ptr`=0 so requester 0 wins next.
- With `PKT_ARB_PRIO0_EN`: requesters 0 and 1 both requesting continuously → requester 1 is never granted until `in_valid[0]` drops. Without the macro → grants alternate 0,1.
